// File: rtl/uart_tx_ctrl_if.sv
// Byte-write handshake between the core and the UART transmit controller.
// wr_opt_byte carries {valid, byte[7:0]}; a byte is taken on a rising clock
// edge where valid and wr_ready are both high.
interface uart_tx_ctrl_if;
    logic [8:0] wr_opt_byte;
    logic       wr_ready;

    // Core side: offers bytes, observes back-pressure.
    modport master (
        output wr_opt_byte,
        input  wr_ready
    );

    // Controller side: accepts bytes, drives back-pressure.
    modport slave (
        input  wr_opt_byte,
        output wr_ready
    );
endinterface : uart_tx_ctrl_if

// File: rtl/uart_tx_ctrl.sv
// UART 8N1 transmit controller: buffers core bytes in a small circular FIFO
// and serialises them LSB first, each bit held CLKS_PER_BIT clocks, with
// back-to-back frames when more bytes are waiting. All outputs are flops.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                              CLK,
    input  logic                              RST,
    uart_tx_ctrl_if.slave                     wr_if,
    output logic                              uart_line_out,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             wr_ready_q, wr_ready_d;
    logic             push;
    logic             pop;

    // Serialiser state
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             line_q, line_d;
    logic             busy_q, busy_d;

    // wr_ready is a flop, so accepting a byte never depends combinationally on wr_opt_byte.
    assign push = wr_if.wr_opt_byte[8] && wr_ready_q;

    // FIFO pointer and level update; power-of-two depth lets the pointers wrap naturally.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned, which would infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Frame sequencer: start bit, eight data bits LSB first, stop bit, chaining into the next byte.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (state_q != S_IDLE && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        line_d    = line_q;
        pop       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                line_d = 1'b1;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    line_d  = 1'b0;
                    cnt_d   = BIT_LAST;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    line_d    = shift_q[0];
                    bit_idx_d = 3'd0;
                    cnt_d     = BIT_LAST;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = BIT_LAST;
                    if (bit_idx_q != 3'd7) begin
                        shift_d   = shift_q >> 1;
                        line_d    = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else begin
                        line_d  = 1'b1;
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (level_q != '0) begin
                        // Next byte starts right after the stop bit, no idle gap.
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        line_d  = 1'b0;
                        cnt_d   = BIT_LAST;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered status outputs, derived from next-state so they line up with the state they describe.
    always_comb begin
        wr_ready_d = (level_d != LEVEL_FULL);
        busy_d     = (state_d != S_IDLE) || (level_d != '0);
    end

    // FIFO data storage.
    always_ff @(posedge CLK) begin
        // NOTE: the byte array has no reset; pointers and level define which entries are valid, so stale contents are never read.
        if (push) begin
            mem[wr_ptr_q] <= wr_if.wr_opt_byte[7:0];
        end
    end

    // State registers with asynchronous reset; the line returns high immediately on reset.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            wr_ready_q <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            line_q     <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            wr_ready_q <= wr_ready_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            line_q     <= line_d;
            busy_q     <= busy_d;
        end
    end

    assign wr_if.wr_ready = wr_ready_q;
    assign uart_line_out  = line_q;
    assign busy           = busy_q;
    assign fifo_level     = level_q;

endmodule : uart_tx_ctrl

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl. The reference model treats the
// transmitter as a byte queue plus a "cycles left in current frame" count;
// the expected line level is looked up from the 10-bit frame pattern.
module tb_uart_tx_ctrl;

    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int FRAME = 10 * N;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             uart_line_out;
    logic             busy;
    logic [LVL_W-1:0] fifo_level;

    uart_tx_ctrl_if wr_if ();

    uart_tx_ctrl #(
        .CLKS_PER_BIT (N),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .wr_if         (wr_if),
        .uart_line_out (uart_line_out),
        .busy          (busy),
        .fifo_level    (fifo_level)
    );

    always #5 CLK = ~CLK;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [7:0] mq[$];
    int         rem       = 0;
    logic [7:0] cur       = 8'h00;
    int         popped    = 0;
    int         max_level = 0;
    bit         saw_full  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        compared++;
        mismatched++;
        $error("FAIL %s: wait budget expired", tag);
    endtask

    // Level of the frame pattern {start=0, d0..d7, stop=1} for the current cycle.
    function automatic logic exp_line();
        int k;
        if (rem == 0) return 1'b1;
        k = (FRAME - rem) / N;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return cur[k-1];
    endfunction

    task automatic check_all(input string ctx);
        check({ctx, ".line"},  32'(uart_line_out), 32'(exp_line()));
        check({ctx, ".ready"}, 32'(wr_if.wr_ready), 32'(mq.size() != DEPTH));
        check({ctx, ".busy"},  32'(busy),           32'((rem > 0) || (mq.size() > 0)));
        check({ctx, ".level"}, 32'(fifo_level),     32'(mq.size()));
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare.
    task automatic cycle(input string ctx, input logic v, input logic [7:0] d, output bit accepted);
        int  size_b;
        bit  do_pop;
        wr_if.wr_opt_byte = {v, d};
        size_b   = mq.size();
        accepted = v && (size_b != DEPTH);
        @(posedge CLK);
        do_pop = (size_b > 0) && (rem <= 1);
        if (rem > 0) rem--;
        if (do_pop) begin
            cur = mq.pop_front();
            rem = FRAME;
            popped++;
        end
        if (accepted) mq.push_back(d);
        if (mq.size() > max_level) max_level = mq.size();
        if (mq.size() == DEPTH) saw_full = 1'b1;
        #1;
        check_all(ctx);
    endtask

    task automatic idle_cycle(input string ctx);
        bit acc;
        cycle(ctx, 1'b0, 8'($urandom), acc);
    endtask

    task automatic push_byte(input string ctx, input logic [7:0] d);
        bit acc;
        int budget;
        acc    = 1'b0;
        budget = 0;
        while (!acc && budget < 20 * FRAME) begin
            cycle(ctx, 1'b1, d, acc);
            budget++;
        end
        if (!acc) timeout({ctx, ".push"});
    endtask

    task automatic drain(input string ctx);
        int budget;
        budget = 0;
        while ((mq.size() != 0 || rem != 0) && budget < (DEPTH + 2) * FRAME) begin
            idle_cycle(ctx);
            budget++;
        end
        if (mq.size() != 0 || rem != 0) timeout({ctx, ".drain"});
        repeat (3) idle_cycle(ctx);
    endtask

    initial begin
        int  start_pop;
        int  budget;
        bit  acc;

        wr_if.wr_opt_byte = 9'h000;

        // Asynchronous reset before any clock edge.
        #2 RST = 1'b1;
        #1 check_all("reset");
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // 1: single byte 0x55.
        push_byte("single", 8'h55);
        drain("single");

        // 2: back-to-back bytes on consecutive cycles.
        cycle("b2b", 1'b1, 8'hA3, acc);
        cycle("b2b", 1'b1, 8'h0F, acc);
        drain("b2b");

        // 3: back-pressure with 12 bytes offered continuously.
        start_pop = popped;
        saw_full  = 1'b0;
        for (int i = 0; i < 12; i++) push_byte("bp", 8'(i));
        check("bp.full_reached", 32'(saw_full), 32'd1);
        drain("bp");
        check("bp.frames_sent", 32'(popped - start_pop), 32'd12);

        // 4: invalid requests are ignored.
        for (int i = 0; i < 50; i++) cycle("invalid", 1'b0, 8'hFF, acc);

        // 5: reset during data bit 3 with two bytes queued.
        cycle("rst", 1'b1, 8'hC4, acc);
        cycle("rst", 1'b1, 8'h19, acc);
        cycle("rst", 1'b1, 8'h7E, acc);
        budget = 0;
        while (!(rem > 0 && (FRAME - rem) / N == 4) && budget < 2 * FRAME) begin
            idle_cycle("rst");
            budget++;
        end
        if (!(rem > 0 && (FRAME - rem) / N == 4)) timeout("rst.reach_bit3");
        check("rst.queued_before", 32'(fifo_level), 32'd2);
        #2 RST = 1'b1;
        mq.delete();
        rem = 0;
        #1 check_all("rst.async");
        @(negedge CLK);
        RST = 1'b0;
        push_byte("rst.after", 8'h81);
        drain("rst.after");

        // 6: pointer wrap with bursts of five random bytes.
        max_level = 0;
        start_pop = popped;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 5; i++) push_byte("wrap", 8'($urandom));
            drain("wrap");
        end
        check("wrap.max_level_le5", 32'(max_level <= 5), 32'd1);
        check("wrap.frames_sent", 32'(popped - start_pop), 32'd20);

        // Random traffic mix.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(0, 2) == 0), 8'($urandom), acc);
        end
        drain("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_uart_tx_ctrl
